cmd_dispatch: RTL and testbench

//  Sequential command dispatcher between the UDP command path and the frame datapath.

---
 rtl/cmd_dispatch.sv | 174 +++++++++++++++++
 tb/tb_cmd_dispatch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatch.sv
// Command dispatcher: decodes UDP command words, computes the BMP sector address and
// sequences SDRAM port selects around one datapath transfer. Optional macro: CMD_DISPATCH_ERR_EN.
module cmd_dispatch #(
    parameter int CH_W            = 2,
    parameter int SDRAM_IDX_W     = 2,
    parameter int SD_IDX_W        = 10,
    parameter int ADDR_W          = 32,
    parameter int SECTORS_PER_IMG = 1800,
    parameter int BMP_BASE        = 8484
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_data,
    input  logic                   xfer_done,
    output logic [SDRAM_IDX_W-1:0] sdram_index,
    output logic [CH_W-1:0]        read_ch,
    output logic [CH_W-1:0]        write_ch,
    output logic [ADDR_W-1:0]      sd_rd_addr,
    output logic                   xfer_start,
`ifdef CMD_DISPATCH_ERR_EN
    output logic                   cmd_err,
`endif
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE,
        WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             move_type_q, move_type_d;
    logic [SD_IDX_W-1:0]    sd_idx_q, sd_idx_d;
    logic [SDRAM_IDX_W-1:0] sdram_index_q, sdram_index_d;
    logic [CH_W-1:0]        read_ch_q, read_ch_d;
    logic [CH_W-1:0]        write_ch_q, write_ch_d;
    logic [ADDR_W-1:0]      sd_rd_addr_q, sd_rd_addr_d;
    logic                   xfer_start_q, xfer_start_d;
    logic                   busy_q, busy_d;
    logic                   cmd_ready_q, cmd_ready_d;

    logic [3:0]             in_type;
    logic [SD_IDX_W-1:0]    in_sd_idx;
    logic                   in_legal;
    logic [CH_W-1:0]        rd_sel;
    logic [CH_W-1:0]        wr_sel;

`ifdef CMD_DISPATCH_ERR_EN
    logic                   cmd_err_q, cmd_err_d;
    logic                   in_illegal;
    assign in_illegal = !in_legal && (in_type != 4'd0);
`endif

    assign in_type   = cmd_data[3:0];
    assign in_sd_idx = cmd_data[4+SDRAM_IDX_W +: SD_IDX_W];
    assign in_legal  = (in_type == 4'd1) || (in_type == 4'd3) ||
                       ((in_type == 4'd2) && (in_sd_idx != '0));

    always_comb begin
        rd_sel = '0;
        wr_sel = '0;
        case (move_type_q)
            4'd1:    wr_sel = CH_W'(1);
            4'd2:    wr_sel = CH_W'(2);
            4'd3:    rd_sel = CH_W'(1);
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        move_type_d   = move_type_q;
        sd_idx_d      = sd_idx_q;
        sdram_index_d = sdram_index_q;
        read_ch_d     = read_ch_q;
        write_ch_d    = write_ch_q;
        sd_rd_addr_d  = sd_rd_addr_q;
        xfer_start_d  = 1'b0;
        busy_d        = busy_q;
        cmd_ready_d   = cmd_ready_q;
`ifdef CMD_DISPATCH_ERR_EN
        cmd_err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Every accepted word is latched; only legal moves leave IDLE.
                if (cmd_valid && cmd_ready_q) begin
                    move_type_d   = in_type;
                    sd_idx_d      = in_sd_idx;
                    sdram_index_d = cmd_data[4 +: SDRAM_IDX_W];
`ifdef CMD_DISPATCH_ERR_EN
                    cmd_err_d     = in_illegal;
`endif
                    if (in_legal) begin
                        state_d     = CALC;
                        cmd_ready_d = 1'b0;
                        busy_d      = 1'b1;
                    end
                end
            end
            CALC: begin
                if (move_type_q == 4'd2) begin
                    sd_rd_addr_d = (ADDR_W'(sd_idx_q) - ADDR_W'(1)) * ADDR_W'(SECTORS_PER_IMG)
                                   + ADDR_W'(BMP_BASE);
                end
                read_ch_d    = rd_sel;
                write_ch_d   = wr_sel;
                xfer_start_d = 1'b1;
                state_d      = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (xfer_done) begin
                    read_ch_d   = '0;
                    write_ch_d  = '0;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            move_type_q   <= '0;
            sd_idx_q      <= '0;
            sdram_index_q <= '0;
            read_ch_q     <= '0;
            write_ch_q    <= '0;
            sd_rd_addr_q  <= '0;
            xfer_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            cmd_ready_q   <= 1'b1;
`ifdef CMD_DISPATCH_ERR_EN
            cmd_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            move_type_q   <= move_type_d;
            sd_idx_q      <= sd_idx_d;
            sdram_index_q <= sdram_index_d;
            read_ch_q     <= read_ch_d;
            write_ch_q    <= write_ch_d;
            sd_rd_addr_q  <= sd_rd_addr_d;
            xfer_start_q  <= xfer_start_d;
            busy_q        <= busy_d;
            cmd_ready_q   <= cmd_ready_d;
`ifdef CMD_DISPATCH_ERR_EN
            cmd_err_q     <= cmd_err_d;
`endif
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign sdram_index = sdram_index_q;
    assign read_ch     = read_ch_q;
    assign write_ch    = write_ch_q;
    assign sd_rd_addr  = sd_rd_addr_q;
    assign xfer_start  = xfer_start_q;
    assign busy        = busy_q;
`ifdef CMD_DISPATCH_ERR_EN
    assign cmd_err     = cmd_err_q;
`endif

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed bench for cmd_dispatch; expected transfers are queued when a command is
// driven and popped by a monitor whenever the DUT raises xfer_start.
module tb_cmd_dispatch;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] wr;
        logic [31:0] idx;
        logic [31:0] addr;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_data;
    logic        xfer_done;
    logic [1:0]  sdram_index;
    logic [1:0]  read_ch;
    logic [1:0]  write_ch;
    logic [31:0] sd_rd_addr;
    logic        xfer_start;
    logic        busy;
`ifdef CMD_DISPATCH_ERR_EN
    logic        cmd_err;
`endif

    int    checks = 0;
    int    errors = 0;
    int    start_count = 0;
    xfer_t sb[$];

    always #5 clk = ~clk;

    cmd_dispatch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .xfer_done  (xfer_done),
        .sdram_index(sdram_index),
        .read_ch    (read_ch),
        .write_ch   (write_ch),
        .sd_rd_addr (sd_rd_addr),
        .xfer_start (xfer_start),
`ifdef CMD_DISPATCH_ERR_EN
        .cmd_err    (cmd_err),
`endif
        .busy       (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: each start pulse must match the oldest queued command.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && xfer_start === 1'b1) begin
            xfer_t e;
            start_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_xfer_start", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("sb_read_ch", 32'(read_ch), e.rd);
                checkOutput("sb_write_ch", 32'(write_ch), e.wr);
                checkOutput("sb_sdram_index", 32'(sdram_index), e.idx);
                checkOutput("sb_sd_rd_addr", sd_rd_addr, e.addr);
            end
        end
    end

    // Accept, CALC, ISSUE, then settle in WAIT; optionally pulse xfer_done early.
    task automatic applyStimulus(input logic [31:0] data, input logic [31:0] rd,
                                 input logic [31:0] wr, input logic [31:0] idx,
                                 input logic [31:0] addr, input bit early_done);
        xfer_t e;
        e.rd = rd; e.wr = wr; e.idx = idx; e.addr = addr;
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_data  = data;
        tick();
        checkOutput("accept_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("accept_busy", 32'(busy), 32'd1);
        checkOutput("calc_no_start", 32'(xfer_start), 32'd0);
        cmd_valid = 1'b0;
        if (early_done) xfer_done = 1'b1;
        tick();
        checkOutput("issue_xfer_start", 32'(xfer_start), 32'd1);
        checkOutput("issue_read_ch", 32'(read_ch), rd);
        checkOutput("issue_write_ch", 32'(write_ch), wr);
        checkOutput("issue_sd_rd_addr", sd_rd_addr, addr);
        tick();
        xfer_done = 1'b0;
        checkOutput("wait_no_start", 32'(xfer_start), 32'd0);
        checkOutput("wait_read_held", 32'(read_ch), rd);
        checkOutput("wait_write_held", 32'(write_ch), wr);
        checkOutput("wait_busy", 32'(busy), 32'd1);
    endtask

    task automatic finish_xfer();
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        checkOutput("done_read_clr", 32'(read_ch), 32'd0);
        checkOutput("done_write_clr", 32'(write_ch), 32'd0);
        checkOutput("done_busy", 32'(busy), 32'd0);
        checkOutput("done_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic nop_cmd(input logic [31:0] data, input logic [31:0] err_exp, input logic [31:0] addr);
        cmd_valid = 1'b1;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        checkOutput("nop_busy", 32'(busy), 32'd0);
        checkOutput("nop_cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef CMD_DISPATCH_ERR_EN
        checkOutput("nop_cmd_err", 32'(cmd_err), err_exp);
`endif
        tick();
        checkOutput("nop_busy2", 32'(busy), 32'd0);
        checkOutput("nop_sd_rd_addr", sd_rd_addr, addr);
`ifdef CMD_DISPATCH_ERR_EN
        checkOutput("nop_cmd_err_once", 32'(cmd_err), 32'd0);
`else
        if (err_exp != 32'd0) checkOutput("nop_no_start", 32'(xfer_start), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = 32'h31;
        xfer_done = 1'b0;
        repeat (2) tick();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_read_ch", 32'(read_ch), 32'd0);
        checkOutput("rst_write_ch", 32'(write_ch), 32'd0);
        checkOutput("rst_sd_rd_addr", sd_rd_addr, 32'd0);
        checkOutput("rst_xfer_start", 32'(xfer_start), 32'd0);
        checkOutput("rst_sdram_index", 32'(sdram_index), 32'd0);
        rst_n = 1'b1;

        $display("[TB] first command right after reset release");
        applyStimulus(32'h31, 32'd0, 32'd1, 32'd3, 32'd0, 1'b0);
        finish_xfer();

        $display("[TB] type 2, sd_idx 2, with xfer_done pulsed during CALC/ISSUE");
        applyStimulus(32'h82, 32'd0, 32'd2, 32'd0, 32'h282C, 1'b1);
        repeat (3) tick();
        checkOutput("hold_write_ch", 32'(write_ch), 32'd2);
        checkOutput("hold_busy", 32'(busy), 32'd1);
        finish_xfer();

        $display("[TB] type 1 keeps the previous sector address");
        applyStimulus(32'h31, 32'd0, 32'd1, 32'd3, 32'h282C, 1'b0);
        finish_xfer();

        $display("[TB] type 3 with a second command held during WAIT");
        applyStimulus(32'h03, 32'd1, 32'd0, 32'd0, 32'h282C, 1'b0);
        begin
            xfer_t e;
            e.rd = 32'd0; e.wr = 32'd1; e.idx = 32'd3; e.addr = 32'h282C;
            sb.push_back(e);
        end
        cmd_valid = 1'b1;
        cmd_data  = 32'h31;
        repeat (3) tick();
        checkOutput("held_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("held_read_ch", 32'(read_ch), 32'd1);
        checkOutput("held_start_count", 32'(start_count), 32'd4);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        checkOutput("held_done_ready", 32'(cmd_ready), 32'd1);
        checkOutput("held_done_read", 32'(read_ch), 32'd0);
        tick();
        cmd_valid = 1'b0;
        checkOutput("held_accept_busy", 32'(busy), 32'd1);
        checkOutput("held_accept_idx", 32'(sdram_index), 32'd3);
        tick();
        checkOutput("held_issue_start", 32'(xfer_start), 32'd1);
        checkOutput("held_issue_write", 32'(write_ch), 32'd1);
        tick();
        finish_xfer();

        $display("[TB] illegal and NOP commands");
        nop_cmd(32'h05, 32'd1, 32'h282C);
        nop_cmd(32'h02, 32'd1, 32'h282C);
        nop_cmd(32'h00, 32'd0, 32'h282C);
        checkOutput("nop_start_count", 32'(start_count), 32'd5);

        $display("[TB] reset during WAIT");
        applyStimulus(32'hD2, 32'd0, 32'd2, 32'd1, 32'h2F34, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_read_ch", 32'(read_ch), 32'd0);
        checkOutput("arst_write_ch", 32'(write_ch), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("arst_sd_rd_addr", sd_rd_addr, 32'd0);
        tick();
        rst_n = 1'b1;
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        tick();
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);

        applyStimulus(32'h82, 32'd0, 32'd2, 32'd0, 32'h282C, 1'b0);
        finish_xfer();

        checkOutput("final_start_count", 32'(start_count), 32'd7);
        checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
